button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Front end that produces the single-cycle `button` press pulse consumed by the operand/result sequencing controller.
- Synchronises the raw asynchronous pad signal and debounces it with a press/release state machine.
- Emits exactly one `button` pulse per physical press, plus a debounced level and a one-shot long-press pulse.
- Sits between the board push-button pad and the controller's `button` input.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal range is 2 or more.
- DEBOUNCE_CYCLES, 10000, number of consecutive identical synchronised samples needed to accept a press or a release; legal range is 1 or more.
- LONG_PRESS_CYCLES, 1000000, number of cycles after press acceptance at which `long_press` fires; legal range is 1 or more.
- ACTIVE_LOW_IN, 0, when 1 the `button_raw` input is inverted before the synchroniser.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- button_raw  input  1  asynchronous pad input, may bounce.
- button  output  1  one-cycle pulse on an accepted press; feeds the controller.
- button_level  output  1  debounced pressed level.
- long_press  output  1  one-cycle pulse when a press has been held LONG_PRESS_CYCLES.

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous and active-low (`rst_n` is sampled on the `clk` rising edge only).
- Reset state: all synchroniser flops 0, state RELEASED, both counters 0, and `button`, `button_level`, `long_press` all 0.
- Outputs: all three are registered; no combinational path from `button_raw` to any output.
- Synchronised sample `s`: (`button_raw` XOR ACTIVE_LOW_IN) passed through SYNC_STAGES flops.
- Debounce counter: width clog2(DEBOUNCE_CYCLES+1).
- Hold counter: width clog2(LONG_PRESS_CYCLES+1); saturates at LONG_PRESS_CYCLES.
- State RELEASED: if s=1, go to PRESS_PENDING with debounce counter = 1.
  - Exception: if DEBOUNCE_CYCLES=1, go directly to PRESSED.
- State PRESS_PENDING:
  - s=0: return to RELEASED, counter cleared.
  - s=1: counter increments.
  - The edge on which the counter would reach DEBOUNCE_CYCLES: go to PRESSED, set `button`=1 for that one cycle, set `button_level`=1, clear the hold counter.
- State PRESSED:
  - Hold counter increments each cycle.
  - The edge on which it reaches LONG_PRESS_CYCLES: `long_press`=1 for one cycle; the counter then saturates and there is no repeat.
  - s=0: go to RELEASE_PENDING with debounce counter = 1. The hold counter freezes.
- State RELEASE_PENDING:
  - s=1: back to PRESSED. No new `button` pulse; the hold counter resumes from its frozen value.
  - s=0: counter increments.
  - On reaching DEBOUNCE_CYCLES: go to RELEASED, `button_level`=0.
- Latency: with `button_raw` stable-pressed before edge 0, `button` is high immediately after edge number SYNC_STAGES+DEBOUNCE_CYCLES-1 (0-based). Release latency to `button_level`=0 is the same.
- Pulse guarantees:
  - `button` is never high for two consecutive cycles.
  - `button` and `long_press` are never high in the same cycle, since LONG_PRESS_CYCLES is 1 or more.
- Reset mid-operation: any state is abandoned. If `button_raw` is still pressed when `rst_n` returns high, it is treated as a fresh press: a full synchroniser plus debounce pass, then exactly one `button` pulse.
- Simultaneous events: bounce during RELEASE_PENDING never generates a second `button` pulse.
- Parameter checks: illegal values stop elaboration via an initial assertion.

Decomposition:
- Package `button_pkg`:
  - typedef enum `btn_state_t` {RELEASED, PRESS_PENDING, PRESSED, RELEASE_PENDING}.
  - Default constants for the three timing parameters.
- Sub-module `sync_ff` (parameter STAGES, 1-bit in/out, reset to 0): reusable synchroniser, instantiated once.
- FSM and counters stay in `button_conditioner`.

Test Plan:
Bench parameters are SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=8.
1. Clean press: raw=1 from edge 0, held 30 cycles -> `button`=1 only after edge 5; `button_level`=1 from edge 5; exactly one pulse.
2. Press bounce: raw 1,1,1,0,1 then stable 1 -> no pulse during the bounce; exactly one pulse, 4 consecutive s=1 samples after the last low.
3. Long press: hold after test 1 -> `long_press`=1 for one cycle after edge 13; no further pulses over 50 more cycles.
4. Release glitch: during PRESSED, raw=0 for 2 cycles then 1 -> `button_level` stays 1; no second `button` pulse. Real release (raw=0 for 10 cycles) -> `button_level`=0 six edges after the drop.
5. Reset mid-press: raw=1, `rst_n`=0 for 2 cycles while in PRESS_PENDING -> all outputs 0. With raw still 1, one `button` pulse appears 6 edges after `rst_n` rises.
6. ACTIVE_LOW_IN=1: raw idle 1, press = drive 0 -> same timing as test 1; raw stuck 1 -> no pulses.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared types and default timing constants for the push-button front end.
// Imported by the synchroniser and by the conditioner FSM.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        PRESS_PENDING   = 2'd1,
        PRESSED         = 2'd2,
        RELEASE_PENDING = 2'd3
    } btn_state_t;

    localparam int DEFAULT_SYNC_STAGES       = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES   = 10000;
    localparam int DEFAULT_LONG_PRESS_CYCLES = 1000000;

endpackage : button_pkg

// File: rtl/button_conditioner_sync.sv
// Multi-flop synchroniser for a single asynchronous bit; every stage clears
// to 0 on a synchronous active-low reset.
module sync_ff
    import button_pkg::*;
#(
    parameter int STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    if (STAGES < 2) begin : g_badStages
        $fatal(1, "sync_ff: STAGES must be 2 or more");
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule : sync_ff

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronises and debounces the pad, then emits a
// one-cycle press pulse, a debounced level and a one-shot long-press pulse.
module button_conditioner
    import button_pkg::*;
#(
    parameter int SYNC_STAGES       = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
    parameter int ACTIVE_LOW_IN     = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_raw,
    output logic button,
    output logic button_level,
    output logic long_press
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DW-1:0] DEB_ONE  = DW'(1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);
    localparam logic          INVERT   = (ACTIVE_LOW_IN != 0);
    localparam logic          FAST_DEB = (DEBOUNCE_CYCLES == 1);

    if (SYNC_STAGES < 2) begin : g_badSync
        $fatal(1, "button_conditioner: SYNC_STAGES must be 2 or more");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_badDeb
        $fatal(1, "button_conditioner: DEBOUNCE_CYCLES must be 1 or more");
    end
    if (LONG_PRESS_CYCLES < 1) begin : g_badLong
        $fatal(1, "button_conditioner: LONG_PRESS_CYCLES must be 1 or more");
    end
    if (ACTIVE_LOW_IN != 0 && ACTIVE_LOW_IN != 1) begin : g_badPol
        $fatal(1, "button_conditioner: ACTIVE_LOW_IN must be 0 or 1");
    end

    logic       w_rawAdj;
    logic       w_s;

    btn_state_t      r_state;
    logic [DW-1:0]   r_debCnt;
    logic [HW-1:0]   r_holdCnt;
    logic            r_button;
    logic            r_level;
    logic            r_long;

    btn_state_t      w_stateNext;
    logic [DW-1:0]   w_debNext;
    logic [HW-1:0]   w_holdNext;
    logic            w_buttonNext;
    logic            w_levelNext;
    logic            w_longNext;

    assign w_rawAdj = button_raw ^ INVERT;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_rawAdj),
        .o_q   (w_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= RELEASED;
            r_debCnt  <= '0;
            r_holdCnt <= '0;
            r_button  <= 1'b0;
            r_level   <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_debCnt  <= w_debNext;
            r_holdCnt <= w_holdNext;
            r_button  <= w_buttonNext;
            r_level   <= w_levelNext;
            r_long    <= w_longNext;
        end
    end

    // Pulses default low so each fires for exactly the one accepting edge;
    // the hold counter only moves while PRESSED and keeps its value otherwise.
    always_comb begin
        w_stateNext  = r_state;
        w_debNext    = r_debCnt;
        w_holdNext   = r_holdCnt;
        w_buttonNext = 1'b0;
        w_levelNext  = r_level;
        w_longNext   = 1'b0;

        case (r_state)
            RELEASED: begin
                if (w_s) begin
                    if (FAST_DEB) begin
                        w_stateNext  = PRESSED;
                        w_debNext    = '0;
                        w_holdNext   = '0;
                        w_buttonNext = 1'b1;
                        w_levelNext  = 1'b1;
                    end else begin
                        w_stateNext = PRESS_PENDING;
                        w_debNext   = DEB_ONE;
                    end
                end
            end

            PRESS_PENDING: begin
                if (!w_s) begin
                    w_stateNext = RELEASED;
                    w_debNext   = '0;
                end else if (r_debCnt + DEB_ONE == DEB_LAST) begin
                    w_stateNext  = PRESSED;
                    w_debNext    = '0;
                    w_holdNext   = '0;
                    w_buttonNext = 1'b1;
                    w_levelNext  = 1'b1;
                end else begin
                    w_debNext = r_debCnt + DEB_ONE;
                end
            end

            PRESSED: begin
                if (!w_s) begin
                    if (FAST_DEB) begin
                        w_stateNext = RELEASED;
                        w_debNext   = '0;
                        w_levelNext = 1'b0;
                    end else begin
                        w_stateNext = RELEASE_PENDING;
                        w_debNext   = DEB_ONE;
                    end
                end else if (r_holdCnt != HOLD_MAX) begin
                    w_holdNext = r_holdCnt + HOLD_ONE;
                    if (r_holdCnt + HOLD_ONE == HOLD_MAX) begin
                        w_longNext = 1'b1;
                    end
                end
            end

            RELEASE_PENDING: begin
                if (w_s) begin
                    w_stateNext = PRESSED;
                    w_debNext   = '0;
                end else if (r_debCnt + DEB_ONE == DEB_LAST) begin
                    w_stateNext = RELEASED;
                    w_debNext   = '0;
                    w_levelNext = 1'b0;
                end else begin
                    w_debNext = r_debCnt + DEB_ONE;
                end
            end

            default: begin
                w_stateNext = RELEASED;
                w_debNext   = '0;
            end
        endcase
    end

    assign button       = r_button;
    assign button_level = r_level;
    assign long_press   = r_long;

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: expected pulse edges are queued as
// stimulus is driven and matched against pulses seen on the outputs.
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst_n;
    logic raw;
    logic rawAl;
    logic button, buttonLevel, longPress;
    logic alButton, alButtonLevel, alLongPress;

    int total = 0;
    int bad = 0;
    int edgeCnt = 0;

    int btnQ[$];
    int lpQ[$];
    int alBtnQ[$];
    int alLpQ[$];

    button_conditioner #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(8), .ACTIVE_LOW_IN(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .button_raw(raw),
        .button(button), .button_level(buttonLevel), .long_press(longPress)
    );

    button_conditioner #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(8), .ACTIVE_LOW_IN(1)
    ) dutAl (
        .clk(clk), .rst_n(rst_n), .button_raw(rawAl),
        .button(alButton), .button_level(alButtonLevel), .long_press(alLongPress)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rawVal, input logic rawAlVal);
        raw   = rawVal;
        rawAl = rawAlVal;
    endtask

    // Advance to the falling edge that follows 0-based rising edge e.
    task automatic stepTo(input int e);
        int guard = 0;
        while (edgeCnt - 1 < e && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic checkPulse(input string tag, input logic seen, ref int q[$]);
        int expEdge;
        if (seen) begin
            if (q.size() == 0) begin
                checkOutput({tag, "Unexpected"}, 1, 0);
            end else begin
                expEdge = q.pop_front();
                checkOutput({tag, "Edge"}, edgeCnt - 1, expEdge);
            end
        end
    endtask

    always @(negedge clk) begin
        checkPulse("btn", button, btnQ);
        checkPulse("lp", longPress, lpQ);
        checkPulse("alBtn", alButton, alBtnQ);
        checkPulse("alLp", alLongPress, alLpQ);
    end

    initial begin
        int t;
        int r;
        logic [3:0] bounceSeq;

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("rstButton", button, 0);
        checkOutput("rstLevel", buttonLevel, 0);
        checkOutput("rstLong", longPress, 0);
        checkOutput("rstAlButton", alButton, 0);
        checkOutput("rstAlLevel", alButtonLevel, 0);
        checkOutput("rstAlLong", alLongPress, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press held long enough for the long-press pulse and beyond.
        applyStimulus(1'b1, 1'b1);
        t = edgeCnt;
        btnQ.push_back(t + 5);
        lpQ.push_back(t + 13);
        stepTo(t + 4);
        checkOutput("pressLevelBefore", buttonLevel, 0);
        stepTo(t + 5);
        checkOutput("pressLevelAfter", buttonLevel, 1);
        stepTo(t + 13 + 50);

        // Short release glitch must not disturb the pressed level.
        applyStimulus(1'b0, 1'b1);
        t = edgeCnt;
        stepTo(t + 1);
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("glitchLevel", buttonLevel, 1);
        end

        // Real release.
        applyStimulus(1'b0, 1'b1);
        t = edgeCnt;
        stepTo(t + 4);
        checkOutput("releaseLevelBefore", buttonLevel, 1);
        stepTo(t + 5);
        checkOutput("releaseLevelAfter", buttonLevel, 0);
        stepTo(t + 12);

        // Bouncing press: 1,1,1,0 then stable 1.
        bounceSeq = 4'b0111;
        t = edgeCnt;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(bounceSeq[i], 1'b1);
            @(negedge clk);
        end
        applyStimulus(1'b1, 1'b1);
        btnQ.push_back(t + 9);
        stepTo(t + 8);
        checkOutput("bounceLevelBefore", buttonLevel, 0);
        stepTo(t + 9);
        checkOutput("bounceLevelAfter", buttonLevel, 1);
        stepTo(t + 12);
        applyStimulus(1'b0, 1'b1);
        t = edgeCnt;
        stepTo(t + 5);
        checkOutput("bounceReleaseLevel", buttonLevel, 0);
        stepTo(t + 10);

        // Reset while the press is still pending.
        applyStimulus(1'b1, 1'b1);
        t = edgeCnt;
        stepTo(t + 2);
        rst_n = 1'b0;
        stepTo(t + 3);
        checkOutput("midRstButton", button, 0);
        checkOutput("midRstLevel", buttonLevel, 0);
        checkOutput("midRstLong", longPress, 0);
        stepTo(t + 4);
        rst_n = 1'b1;
        r = edgeCnt;
        btnQ.push_back(r + 5);
        stepTo(r + 4);
        checkOutput("postRstLevelBefore", buttonLevel, 0);
        stepTo(r + 5);
        checkOutput("postRstLevelAfter", buttonLevel, 1);
        stepTo(r + 7);
        applyStimulus(1'b0, 1'b1);
        t = edgeCnt;
        stepTo(t + 5);
        checkOutput("postRstReleaseLevel", buttonLevel, 0);
        stepTo(t + 10);

        // Active-low pad: press is a drive to 0.
        applyStimulus(1'b0, 1'b0);
        t = edgeCnt;
        alBtnQ.push_back(t + 5);
        alLpQ.push_back(t + 13);
        stepTo(t + 4);
        checkOutput("alLevelBefore", alButtonLevel, 0);
        stepTo(t + 5);
        checkOutput("alLevelAfter", alButtonLevel, 1);
        stepTo(t + 20);
        applyStimulus(1'b0, 1'b1);
        t = edgeCnt;
        stepTo(t + 5);
        checkOutput("alReleaseLevel", alButtonLevel, 0);
        stepTo(t + 30);

        checkOutput("btnQLeft", btnQ.size(), 0);
        checkOutput("lpQLeft", lpQ.size(), 0);
        checkOutput("alBtnQLeft", alBtnQ.size(), 0);
        checkOutput("alLpQLeft", alLpQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_button_conditioner
